// File: rtl/race_pkg.sv
// Shared types, default geometry and width helpers for the road/track datapath.
package race_pkg;

    typedef enum logic [1:0] {
        ST_HOLD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } race_state_t;

    localparam int unsigned DEF_MAX_SPEED    = 8;
    localparam int unsigned DEF_ACCEL_FRAMES = 4;
    localparam int unsigned DEF_TRACK_LEN    = 4096;
    localparam int unsigned DEF_ROAD_H       = 480;

    // Bits needed to hold the values 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/road_scroll_ctrl_frame_divider.sv
// Frame divider: counts RUN frame ticks 0..ACCEL_FRAMES-1 and flags the last one as a speed step.
module frame_divider
    import race_pkg::*;
#(
    parameter int unsigned ACCEL_FRAMES = DEF_ACCEL_FRAMES
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int unsigned W_CNT = cnt_w(ACCEL_FRAMES);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(ACCEL_FRAMES - 1);

    logic [W_CNT-1:0] r_cnt;

    // Step must act on the same tick that the counter sits at its last value.
    assign step = en && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= step ? '0 : r_cnt + W_CNT'(1);
        end
    end

endmodule

// File: rtl/road_scroll_ctrl.sv
// Per-frame speed, road scroll and distance sequencer for the race datapath.
// Optional ROAD_FRICTION_EN: coasting (no key held) bleeds one speed unit per step.
module road_scroll_ctrl
    import race_pkg::*;
#(
    parameter int unsigned MAX_SPEED    = DEF_MAX_SPEED,
    parameter int unsigned ACCEL_FRAMES = DEF_ACCEL_FRAMES,
    parameter int unsigned TRACK_LEN    = DEF_TRACK_LEN,
    parameter int unsigned ROAD_H       = DEF_ROAD_H
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 frame_tick,
    input  logic                                 pause,
    input  logic                                 game_reset,
    input  logic                                 accel_key,
    input  logic                                 brake_key,
    output logic [cnt_w(MAX_SPEED + 1)-1:0]      speed,
    output logic [cnt_w(ROAD_H)-1:0]             scroll_y,
    output logic [cnt_w(TRACK_LEN + 1)-1:0]      distance,
    output logic                                 finish_zone,
    output logic                                 race_done,
    output logic                                 moving
);

    localparam int unsigned W_SPD  = cnt_w(MAX_SPEED + 1);
    localparam int unsigned W_SCR  = cnt_w(ROAD_H);
    localparam int unsigned W_SCR1 = W_SCR + 1;
    localparam int unsigned W_DST  = cnt_w(TRACK_LEN + 1);
    localparam int unsigned W_DST1 = W_DST + 1;

    race_state_t      r_state;
    logic [W_SPD-1:0] r_speed;
    logic [W_SCR-1:0] r_scroll;
    logic [W_DST-1:0] r_dist;

    logic              w_run_tick;
    logic              w_div_clr;
    logic              w_step;
    logic [W_SPD-1:0]  w_spd_next;
    logic [W_SCR1-1:0] w_scr_sum;
    logic [W_SCR-1:0]  w_scr_next;
    logic [W_DST1-1:0] w_dst_sum;
    logic [W_DST-1:0]  w_dst_next;
    logic              w_hit;

    // Only a tick that survives game_reset/pause in RUN advances the divider.
    assign w_run_tick = (r_state == ST_RUN) && frame_tick && !pause && !game_reset;
    assign w_div_clr  = game_reset || (r_state == ST_HOLD);

    frame_divider #(
        .ACCEL_FRAMES (ACCEL_FRAMES)
    ) u_frame_divider (
        .clk   (clk),
        .reset (reset),
        .clr   (w_div_clr),
        .en    (w_run_tick),
        .step  (w_step)
    );

    // Next speed (brake > accel > coast) and next position from the pre-update speed.
    always_comb begin
        w_spd_next = r_speed;
        if (brake_key) begin
            if (r_speed != '0) w_spd_next = r_speed - W_SPD'(1);
        end else if (accel_key) begin
            if (w_step && (r_speed < W_SPD'(MAX_SPEED))) w_spd_next = r_speed + W_SPD'(1);
        end else begin
`ifdef ROAD_FRICTION_EN
            if (w_step && (r_speed != '0)) w_spd_next = r_speed - W_SPD'(1);
`else
            w_spd_next = r_speed;
`endif
        end

        w_scr_sum  = {1'b0, r_scroll} + W_SCR1'(r_speed);
        w_scr_next = (w_scr_sum >= W_SCR1'(ROAD_H)) ? W_SCR'(w_scr_sum - W_SCR1'(ROAD_H))
                                                    : W_SCR'(w_scr_sum);

        w_dst_sum  = {1'b0, r_dist} + W_DST1'(r_speed);
        w_hit      = (w_dst_sum >= W_DST1'(TRACK_LEN));
        w_dst_next = w_hit ? W_DST'(TRACK_LEN) : W_DST'(w_dst_sum);
    end

    always_ff @(posedge clk) begin
        if (reset || game_reset) begin
            r_state  <= ST_HOLD;
            r_speed  <= '0;
            r_scroll <= '0;
            r_dist   <= '0;
        end else if (pause) begin
            if (r_state == ST_RUN) r_state <= ST_PAUSED;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (frame_tick) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (frame_tick) begin
                        r_scroll <= w_scr_next;
                        r_dist   <= w_dst_next;
                        if (w_hit) begin
                            r_speed <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_speed <= w_spd_next;
                        end
                    end
                end
                ST_PAUSED: r_state <= ST_RUN;
                ST_DONE:   r_state <= ST_DONE;
                default:   r_state <= ST_HOLD;
            endcase
        end
    end

    assign speed       = r_speed;
    assign scroll_y    = r_scroll;
    assign distance    = r_dist;
    assign finish_zone = (r_dist >= W_DST'(TRACK_LEN - ROAD_H));
    assign race_done   = (r_state == ST_DONE);
    assign moving      = (r_state == ST_RUN) && (r_speed != '0);

endmodule

// File: tb/tb_road_scroll_ctrl.sv
// Directed bench for road_scroll_ctrl: one continuous race walked through scenario tasks.
module tb_road_scroll_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        pause;
    logic        game_reset;
    logic        accel_key;
    logic        brake_key;
    logic [3:0]  speed;
    logic [8:0]  scroll_y;
    logic [12:0] distance;
    logic        finish_zone;
    logic        race_done;
    logic        moving;

    int n_vec = 0;
    int n_err = 0;

    road_scroll_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .game_reset  (game_reset),
        .accel_key   (accel_key),
        .brake_key   (brake_key),
        .speed       (speed),
        .scroll_y    (scroll_y),
        .distance    (distance),
        .finish_zone (finish_zone),
        .race_done   (race_done),
        .moving      (moving)
    );

    always #5 clk = ~clk;

    // One frame_tick pulse; returns at the falling edge after the sampling edge.
    task automatic do_tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; game_reset = 1'b0; pause = 1'b0;
        frame_tick = 1'b0; accel_key = 1'b0; brake_key = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++; if (speed !== 4'd0) begin n_err++; $display("FAIL reset_speed got %0d want 0", speed); end
        n_vec++; if (scroll_y !== 9'd0) begin n_err++; $display("FAIL reset_scroll got %0d want 0", scroll_y); end
        n_vec++; if (distance !== 13'd0) begin n_err++; $display("FAIL reset_distance got %0d want 0", distance); end
        n_vec++; if (finish_zone !== 1'b0) begin n_err++; $display("FAIL reset_finish got %0b want 0", finish_zone); end
        n_vec++; if (race_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0b want 0", race_done); end
        n_vec++; if (moving !== 1'b0) begin n_err++; $display("FAIL reset_moving got %0b want 0", moving); end
    endtask

    task automatic test_accel();
        accel_key = 1'b1;
        do_tick();
        n_vec++; if (speed !== 4'd0) begin n_err++; $display("FAIL hold_tick_speed got %0d want 0", speed); end
        n_vec++; if (moving !== 1'b0) begin n_err++; $display("FAIL hold_tick_moving got %0b want 0", moving); end
        run_ticks(4);
        n_vec++; if (speed !== 4'd1) begin n_err++; $display("FAIL accel_tick5_speed got %0d want 1", speed); end
        n_vec++; if (distance !== 13'd0) begin n_err++; $display("FAIL accel_tick5_dist got %0d want 0", distance); end
        run_ticks(2);
        // Brake pulse between ticks must be ignored.
        @(negedge clk); brake_key = 1'b1;
        @(negedge clk); brake_key = 1'b0;
        run_ticks(2);
        n_vec++; if (speed !== 4'd2) begin n_err++; $display("FAIL accel_tick9_speed got %0d want 2", speed); end
        n_vec++; if (distance !== 13'd4) begin n_err++; $display("FAIL accel_tick9_dist got %0d want 4", distance); end
        n_vec++; if (scroll_y !== 9'd4) begin n_err++; $display("FAIL accel_tick9_scroll got %0d want 4", scroll_y); end
        n_vec++; if (moving !== 1'b1) begin n_err++; $display("FAIL accel_moving got %0b want 1", moving); end
    endtask

    task automatic test_brake_both();
        run_ticks(4);
        n_vec++; if (speed !== 4'd3) begin n_err++; $display("FAIL pre_brake_speed got %0d want 3", speed); end
        n_vec++; if (distance !== 13'd12) begin n_err++; $display("FAIL pre_brake_dist got %0d want 12", distance); end
        brake_key = 1'b1;
        run_ticks(2);
        n_vec++; if (speed !== 4'd1) begin n_err++; $display("FAIL both_keys_speed got %0d want 1", speed); end
        n_vec++; if (distance !== 13'd17) begin n_err++; $display("FAIL both_keys_dist got %0d want 17", distance); end
        run_ticks(3);
        n_vec++; if (speed !== 4'd0) begin n_err++; $display("FAIL brake_floor_speed got %0d want 0", speed); end
        n_vec++; if (distance !== 13'd18) begin n_err++; $display("FAIL brake_floor_dist got %0d want 18", distance); end
        n_vec++; if (scroll_y !== 9'd18) begin n_err++; $display("FAIL brake_floor_scroll got %0d want 18", scroll_y); end
        brake_key = 1'b0;
    endtask

    task automatic test_pause();
        run_ticks(19);
        n_vec++; if (speed !== 4'd5) begin n_err++; $display("FAIL pre_pause_speed got %0d want 5", speed); end
        n_vec++; if (distance !== 13'd58) begin n_err++; $display("FAIL pre_pause_dist got %0d want 58", distance); end
        // Pause coincident with a tick: the tick is discarded.
        @(negedge clk); pause = 1'b1; frame_tick = 1'b1;
        @(negedge clk); frame_tick = 1'b0;
        n_vec++; if (speed !== 4'd5) begin n_err++; $display("FAIL pause_tick_speed got %0d want 5", speed); end
        n_vec++; if (distance !== 13'd58) begin n_err++; $display("FAIL pause_tick_dist got %0d want 58", distance); end
        n_vec++; if (scroll_y !== 9'd58) begin n_err++; $display("FAIL pause_tick_scroll got %0d want 58", scroll_y); end
        run_ticks(10);
        n_vec++; if (speed !== 4'd5) begin n_err++; $display("FAIL paused_speed got %0d want 5", speed); end
        n_vec++; if (distance !== 13'd58) begin n_err++; $display("FAIL paused_dist got %0d want 58", distance); end
        n_vec++; if (race_done !== 1'b0) begin n_err++; $display("FAIL paused_done got %0b want 0", race_done); end
        @(negedge clk); pause = 1'b0;
        @(negedge clk);
        do_tick();
        n_vec++; if (speed !== 4'd5) begin n_err++; $display("FAIL resume_speed got %0d want 5", speed); end
        n_vec++; if (distance !== 13'd63) begin n_err++; $display("FAIL resume_dist got %0d want 63", distance); end
        n_vec++; if (moving !== 1'b1) begin n_err++; $display("FAIL resume_moving got %0b want 1", moving); end
    endtask

    task automatic test_scroll_wrap();
        run_ticks(11);
        n_vec++; if (speed !== 4'd8) begin n_err++; $display("FAIL top_speed got %0d want 8", speed); end
        n_vec++; if (distance !== 13'd130) begin n_err++; $display("FAIL top_speed_dist got %0d want 130", distance); end
        run_ticks(43);
        n_vec++; if (speed !== 4'd8) begin n_err++; $display("FAIL speed_cap got %0d want 8", speed); end
        n_vec++; if (scroll_y !== 9'd474) begin n_err++; $display("FAIL pre_wrap_scroll got %0d want 474", scroll_y); end
        do_tick();
        n_vec++; if (scroll_y !== 9'd2) begin n_err++; $display("FAIL wrap_scroll got %0d want 2", scroll_y); end
        n_vec++; if (distance !== 13'd482) begin n_err++; $display("FAIL wrap_dist got %0d want 482", distance); end
    endtask

    task automatic test_finish();
        run_ticks(391);
        n_vec++; if (distance !== 13'd3610) begin n_err++; $display("FAIL below_zone_dist got %0d want 3610", distance); end
        n_vec++; if (finish_zone !== 1'b0) begin n_err++; $display("FAIL below_zone got %0b want 0", finish_zone); end
        do_tick();
        n_vec++; if (finish_zone !== 1'b1) begin n_err++; $display("FAIL in_zone got %0b want 1", finish_zone); end
        run_ticks(59);
        n_vec++; if (distance !== 13'd4090) begin n_err++; $display("FAIL pre_finish_dist got %0d want 4090", distance); end
        n_vec++; if (scroll_y !== 9'd250) begin n_err++; $display("FAIL pre_finish_scroll got %0d want 250", scroll_y); end
        n_vec++; if (race_done !== 1'b0) begin n_err++; $display("FAIL pre_finish_done got %0b want 0", race_done); end
        do_tick();
        n_vec++; if (distance !== 13'd4096) begin n_err++; $display("FAIL finish_dist got %0d want 4096", distance); end
        n_vec++; if (race_done !== 1'b1) begin n_err++; $display("FAIL finish_done got %0b want 1", race_done); end
        n_vec++; if (speed !== 4'd0) begin n_err++; $display("FAIL finish_speed got %0d want 0", speed); end
        n_vec++; if (moving !== 1'b0) begin n_err++; $display("FAIL finish_moving got %0b want 0", moving); end
        n_vec++; if (scroll_y !== 9'd258) begin n_err++; $display("FAIL finish_scroll got %0d want 258", scroll_y); end
    endtask

    task automatic test_done_and_game_reset();
        run_ticks(3);
        @(negedge clk); pause = 1'b1;
        @(negedge clk); pause = 1'b0;
        do_tick();
        n_vec++; if (distance !== 13'd4096) begin n_err++; $display("FAIL done_frozen_dist got %0d want 4096", distance); end
        n_vec++; if (scroll_y !== 9'd258) begin n_err++; $display("FAIL done_frozen_scroll got %0d want 258", scroll_y); end
        n_vec++; if (speed !== 4'd0) begin n_err++; $display("FAIL done_frozen_speed got %0d want 0", speed); end
        n_vec++; if (race_done !== 1'b1) begin n_err++; $display("FAIL done_held got %0b want 1", race_done); end
        @(negedge clk); game_reset = 1'b1;
        @(negedge clk); game_reset = 1'b0;
        n_vec++; if (distance !== 13'd0) begin n_err++; $display("FAIL greset_dist got %0d want 0", distance); end
        n_vec++; if (scroll_y !== 9'd0) begin n_err++; $display("FAIL greset_scroll got %0d want 0", scroll_y); end
        n_vec++; if (race_done !== 1'b0) begin n_err++; $display("FAIL greset_done got %0b want 0", race_done); end
        n_vec++; if (finish_zone !== 1'b0) begin n_err++; $display("FAIL greset_finish got %0b want 0", finish_zone); end
        do_tick();
        n_vec++; if (distance !== 13'd0) begin n_err++; $display("FAIL restart_tick_dist got %0d want 0", distance); end
    endtask

    task automatic test_friction();
        run_ticks(16);
        n_vec++; if (speed !== 4'd4) begin n_err++; $display("FAIL pre_coast_speed got %0d want 4", speed); end
        n_vec++; if (distance !== 13'd24) begin n_err++; $display("FAIL pre_coast_dist got %0d want 24", distance); end
        accel_key = 1'b0;
        run_ticks(8);
`ifdef ROAD_FRICTION_EN
        n_vec++; if (speed !== 4'd2) begin n_err++; $display("FAIL coast_speed got %0d want 2", speed); end
        n_vec++; if (distance !== 13'd52) begin n_err++; $display("FAIL coast_dist got %0d want 52", distance); end
`else
        n_vec++; if (speed !== 4'd4) begin n_err++; $display("FAIL coast_speed got %0d want 4", speed); end
        n_vec++; if (distance !== 13'd56) begin n_err++; $display("FAIL coast_dist got %0d want 56", distance); end
`endif
    endtask

    initial begin
        test_reset();
        test_accel();
        test_brake_both();
        test_pause();
        test_scroll_wrap();
        test_finish();
        test_done_and_game_reset();
        test_friction();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
